// File: rtl/cache_pkg.sv
// Shared geometry, address-field helpers and FSM state type for the cache refill path.
package cache_pkg;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 10;
  localparam int OFF_W  = 2;
  localparam int ADR_W  = 15;
  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;

  typedef enum logic [1:0] {IDLE, FETCH, FILL, RESPOND} state_e;

  function automatic logic [TAG_W-1:0] adr_tag(input logic [ADR_W-1:0] a);
    return a[ADR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] adr_idx(input logic [ADR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] adr_off(input logic [ADR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  // Block-aligned part of the address ({tag, index}).
  function automatic logic [ADR_W-OFF_W-1:0] adr_blk(input logic [ADR_W-1:0] a);
    return a[ADR_W-1:OFF_W];
  endfunction
endpackage

// File: rtl/cache_refill_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                             cnt_q <= '0;
    else if (inc_i && (cnt_q != {W{1'b1}})) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cache_refill_controller.sv
// Load-miss refill controller: zero-wait hits, four-word block fetch on a miss,
// one-cycle block write, then respond from the refilled line.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADR_W-1:0]  cpu_adr,
  output logic              cpu_ready,
  output logic [ADR_W-1:0]  cache_adr,
  input  logic              cache_hit,
  output logic [BLK_W-1:0]  cache_wblock,
  output logic              cache_write,
  output logic              mem_read,
  output logic [ADR_W-1:0]  mem_adr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  state_e                         state_q;
  logic [OFF_W-1:0]               wcnt_q;
  logic [ADR_W-1:0]               lat_adr_q;
  logic [(1<<OFF_W)-1:0][WORD_W-1:0] buf_q;
  logic                           idle_req, hit_inc, miss_inc;

  assign idle_req = (state_q == IDLE) && cpu_req;
  assign hit_inc  = idle_req && cache_hit;
  assign miss_inc = idle_req && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      lat_adr_q <= '0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (miss_inc) begin
          lat_adr_q <= cpu_adr;
          wcnt_q    <= '0;
          state_q   <= FETCH;
        end
        FETCH: if (mem_ready) begin
          buf_q[wcnt_q] <= mem_rdata;
          wcnt_q        <= wcnt_q + 1'b1;
          if (wcnt_q == {OFF_W{1'b1}}) state_q <= FILL;
        end
        FILL:    state_q <= RESPOND;
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The lookup port follows the CPU only while idle; a refill owns it otherwise.
  assign cache_adr    = (state_q == IDLE) ? cpu_adr : lat_adr_q;
  assign cpu_ready    = hit_inc || (state_q == RESPOND);
  assign mem_read     = (state_q == FETCH);
  assign mem_adr      = {adr_blk(lat_adr_q), wcnt_q};
  assign cache_write  = (state_q == FILL);
  assign cache_wblock = buf_q;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc_i(hit_inc), .cnt_o(hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc_i(miss_inc), .cnt_o(miss_count)
  );
endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench: behavioural direct-mapped cache and variable-latency memory around the controller.
module tb_cache_refill_controller;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [14:0]       cpu_adr;
  logic              cpu_ready;
  logic [14:0]       cache_adr;
  logic              cache_hit;
  logic [127:0]      cache_wblock;
  logic              cache_write;
  logic              mem_read;
  logic [14:0]       mem_adr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_refill_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_ready(cpu_ready),
    .cache_adr(cache_adr), .cache_hit(cache_hit), .cache_wblock(cache_wblock),
    .cache_write(cache_write), .mem_read(mem_read), .mem_adr(mem_adr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // Cache array model; valid bits share rst.
  logic         valid_m [1024];
  logic [2:0]   tag_m   [1024];
  logic [127:0] data_m  [1024];
  logic [31:0]  rdata;

  always @* begin
    cache_hit = valid_m[cache_adr[11:2]] && (tag_m[cache_adr[11:2]] == cache_adr[14:12]);
    rdata     = data_m[cache_adr[11:2]][{cache_adr[1:0], 5'd0} +: 32];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) valid_m[i] <= 1'b0;
    end else if (cache_write) begin
      valid_m[cache_adr[11:2]] <= 1'b1;
      tag_m[cache_adr[11:2]]   <= cache_adr[14:12];
      data_m[cache_adr[11:2]]  <= cache_wblock;
    end
  end

  // Memory model: data = base + word offset; latency mem_lat, or a strobe every cycle.
  int          mem_lat = 1;
  bit          mem_b2b = 1'b0;
  logic [31:0] mem_base = 32'h0;
  int          lat_cnt = 0;
  logic        model_rdy = 1'b0;
  logic        force_rdy = 1'b0;

  assign mem_ready = model_rdy | force_rdy;
  assign mem_rdata = mem_base + {30'd0, mem_adr[1:0]};

  always @(posedge clk) begin
    if (rst || !mem_read) begin
      model_rdy <= 1'b0; lat_cnt <= 0;
    end else if (mem_b2b)            model_rdy <= 1'b1;
    else if (model_rdy)              model_rdy <= 1'b0;
    else if (lat_cnt + 1 >= mem_lat) begin model_rdy <= 1'b1; lat_cnt <= 0; end
    else                             lat_cnt <= lat_cnt + 1;
  end

  // Transaction monitor: captured word addresses, block writes, address stability.
  logic [14:0]  adr_q[$];
  logic [127:0] blk_q[$];
  int           rd_cycles = 0;
  logic         prev_wait = 1'b0;
  logic [14:0]  prev_adr = '0;

  always @(negedge clk) begin
    if (mem_read) rd_cycles++;
    if (mem_read && prev_wait) begin
      checks++;
      if (mem_adr !== prev_adr) begin
        errors++;
        $display("FAIL mem_adr_stable: got %0h expected %0h", mem_adr, prev_adr);
      end
    end
    prev_wait = mem_read && !mem_ready;
    prev_adr  = mem_adr;
    if (mem_read && mem_ready) adr_q.push_back(mem_adr);
    if (cache_write)           blk_q.push_back(cache_wblock);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [14:0] a, output int cyc, output logic [31:0] rd, output bit to);
    @(negedge clk);
    cpu_req = 1'b1; cpu_adr = a;
    #1;
    cyc = 0;
    while (!cpu_ready && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    to = !cpu_ready;
    rd = rdata;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic [14:0]  adr;
    logic [31:0]  base;
    int           lat;
    bit           b2b;
    bit           hit;
    logic [31:0]  rd;
    int           hits;
    int           misses;
    logic [127:0] blk;
  } vec_t;

  vec_t tv[8];

  initial begin
    int          cyc, n;
    logic [31:0] rd;
    bit          to;

    tv[0] = '{15'h1234, 32'hA0, 1, 1'b0, 1'b0, 32'hA0, 0, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    tv[1] = '{15'h1235, 32'hA0, 1, 1'b0, 1'b1, 32'hA1, 1, 1, 128'h0};
    tv[2] = '{15'h5234, 32'hB0, 7, 1'b0, 1'b0, 32'hB0, 1, 2, {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    tv[3] = '{15'h1234, 32'hA0, 1, 1'b1, 1'b0, 32'hA0, 1, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    tv[4] = '{15'h1237, 32'hA0, 1, 1'b0, 1'b1, 32'hA3, 2, 3, 128'h0};
    tv[5] = '{15'h0003, 32'hD0, 2, 1'b0, 1'b0, 32'hD3, 2, 4, {32'hD3, 32'hD2, 32'hD1, 32'hD0}};
    tv[6] = '{15'h7FFF, 32'hE0, 1, 1'b0, 1'b0, 32'hE3, 2, 5, {32'hE3, 32'hE2, 32'hE1, 32'hE0}};
    tv[7] = '{15'h7FFE, 32'hE0, 1, 1'b0, 1'b1, 32'hE2, 3, 5, 128'h0};

    rst = 1'b1; cpu_req = 1'b0; cpu_adr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_cpu_ready",   cpu_ready,   0);
    chk("reset_cache_write", cache_write, 0);
    chk("reset_mem_read",    mem_read,    0);
    chk("reset_hit_count",   hit_count,   0);
    chk("reset_miss_count",  miss_count,  0);

    foreach (tv[i]) begin
      mem_base = tv[i].base; mem_lat = tv[i].lat; mem_b2b = tv[i].b2b;
      adr_q.delete(); blk_q.delete(); rd_cycles = 0;
      load(tv[i].adr, cyc, rd, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_zero_wait", i), (cyc == 0), tv[i].hit);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d_hit_count", i), hit_count, tv[i].hits);
      chk($sformatf("v%0d_miss_count", i), miss_count, tv[i].misses);
      if (tv[i].hit) begin
        chk($sformatf("v%0d_mem_read_cycles", i), rd_cycles, 0);
        chk($sformatf("v%0d_block_writes", i), blk_q.size(), 0);
      end else begin
        chk($sformatf("v%0d_words", i), adr_q.size(), 4);
        if (adr_q.size() == 4)
          for (int k = 0; k < 4; k++)
            chk($sformatf("v%0d_mem_adr%0d", i, k), adr_q[k], {tv[i].adr[14:2], 2'(k)});
        chk($sformatf("v%0d_block_writes", i), blk_q.size(), 1);
        if (blk_q.size() == 1) chk($sformatf("v%0d_wblock", i), blk_q[0], tv[i].blk);
      end
    end

    // Reset in the middle of a refill, then a stray late mem_ready.
    mem_base = 32'hF0; mem_lat = 1; mem_b2b = 1'b0; adr_q.delete(); blk_q.delete();
    @(negedge clk); cpu_req = 1'b1; cpu_adr = 15'h2468;
    n = 0;
    while (adr_q.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("rst_fetch_timeout", (n >= 50), 0);
    @(negedge clk); rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_cpu_ready",   cpu_ready,   0);
    chk("rst_mid_cache_write", cache_write, 0);
    chk("rst_mid_mem_read",    mem_read,    0);
    chk("rst_mid_hit_count",   hit_count,   0);
    chk("rst_mid_miss_count",  miss_count,  0);
    @(negedge clk); rst = 1'b0; force_rdy = 1'b1;
    @(negedge clk); force_rdy = 1'b0; #1;
    chk("late_rdy_mem_read",    mem_read,    0);
    chk("late_rdy_cache_write", cache_write, 0);
    chk("late_rdy_cpu_ready",   cpu_ready,   0);
    adr_q.delete(); blk_q.delete();
    load(15'h2468, cyc, rd, to);
    chk("post_rst_timeout", to, 0);
    chk("post_rst_miss", (cyc != 0), 1);
    chk("post_rst_rdata", rd, 32'hF0);
    chk("post_rst_miss_count", miss_count, 1);
    chk("post_rst_first_adr", (adr_q.size() > 0) ? adr_q[0] : 15'h7FFF, 15'h2468);
    chk("post_rst_wblock", (blk_q.size() == 1) ? blk_q[0] : 128'h0,
        {32'hF3, 32'hF2, 32'hF1, 32'hF0});

    // Hit counter saturation with a request held over consecutive hits.
    @(negedge clk); cpu_req = 1'b1; cpu_adr = 15'h2468;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", hit_count, 16'hFFFE);
    @(posedge clk); #1 chk("sat_ffff", hit_count, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 chk("sat_hold", hit_count, 16'hFFFF);
    chk("sat_miss_count", miss_count, 1);
    chk("sat_hit_ready", cpu_ready, 1);
    @(negedge clk); cpu_req = 1'b0;

    // Request dropped during FETCH: refill still completes and RESPOND still fires.
    mem_base = 32'h50; mem_lat = 1; blk_q.delete();
    @(negedge clk); cpu_req = 1'b1; cpu_adr = 15'h0ABC;
    @(negedge clk); cpu_req = 1'b0; #1;
    n = 0;
    while (!cpu_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("drop_req_respond", cpu_ready, 1);
    chk("drop_req_rdata", rdata, 32'h50);
    chk("drop_req_miss_count", miss_count, 2);
    chk("drop_req_writes", blk_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
